// File: rtl/plru_victim_select.sv
// Tree pseudo-LRU victim selection per cache set, fed by the hit/miss stage.
// Define PLRU_STATS_EN to build the saturating hit/miss/dirty-eviction counters.
module plru_victim_select #(
  parameter int unsigned i_size   = 32,
  parameter int unsigned c_size   = 24,
  parameter int unsigned d_size   = 6,
  parameter int unsigned protocol = 2,
  parameter int unsigned a_size   = 8,
  localparam int unsigned WAY_W   = $clog2(a_size),
  localparam int unsigned IDX_W   = c_size - d_size - WAY_W
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req,
  input  logic [IDX_W-1:0]                   index,
  input  logic                               hit,
  input  logic                               miss,
  input  logic [WAY_W-1:0]                   block_select,
  input  logic [a_size-1:0][protocol-1:0]    MESI,
  output logic                               ready,
  output logic                               done,
  output logic [WAY_W-1:0]                   victim_way,
  output logic                               evict_dirty,
  output logic                               err,
  output logic [31:0]                        hit_count,
  output logic [31:0]                        miss_count,
  output logic [31:0]                        evict_count
);

  localparam int unsigned Sets = 1 << IDX_W;

  if (i_size < c_size || a_size < 2 || (a_size & (a_size - 1)) != 0) begin : g_cfg_err
    $error("plru_victim_select: invalid parameter set");
  end

  typedef enum logic [1:0] {StIdle, StLookup, StUpdate} state_e;

  state_e                            r_state, w_state_next;
  logic [a_size-2:0]                 r_plru [Sets];
  logic [IDX_W-1:0]                  r_index;
  logic                              r_hit, r_miss;
  logic [WAY_W-1:0]                  r_bsel;
  logic [a_size-1:0][protocol-1:0]   r_mesi;
  logic [a_size-2:0]                 r_bits;
  logic [WAY_W-1:0]                  r_victim_way;
  logic                              r_evict_dirty, r_done, r_err;

  logic [a_size-2:0]                 w_rd_bits, w_new_bits;
  logic [WAY_W-1:0]                  w_walk_way, w_way;
  logic                              w_dirty, w_err, w_free;
  int unsigned                       w_walk_node, w_upd_node;

  assign w_rd_bits = r_plru[r_index];

  // Descend from the root; each bit names the subtree holding the victim.
  always_comb begin
    w_walk_way  = '0;
    w_walk_node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      w_walk_way[WAY_W-1-l] = w_rd_bits[w_walk_node];
      w_walk_node = 2 * w_walk_node + (w_rd_bits[w_walk_node] ? 2 : 1);
    end
  end

  always_comb begin
    w_err  = (r_hit == r_miss);
    w_free = (r_mesi[r_bsel] == '0);
    if (r_hit) begin
      w_way   = r_bsel;
      w_dirty = 1'b0;
    end else if (w_free) begin
      w_way   = r_bsel;
      w_dirty = 1'b0;
    end else begin
      w_way   = w_walk_way;
      w_dirty = (r_mesi[w_walk_way] == protocol'(3));
    end
  end

  // Point every node on the path away from the touched way.
  always_comb begin
    w_new_bits = r_bits;
    w_upd_node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      w_new_bits[w_upd_node] = ~r_victim_way[WAY_W-1-l];
      w_upd_node = 2 * w_upd_node + (r_victim_way[WAY_W-1-l] ? 2 : 1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (req) w_state_next = StLookup;
      StLookup: w_state_next = w_err ? StIdle : StUpdate;
      StUpdate: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_index       <= '0;
      r_hit         <= 1'b0;
      r_miss        <= 1'b0;
      r_bsel        <= '0;
      r_mesi        <= '0;
      r_bits        <= '0;
      r_victim_way  <= '0;
      r_evict_dirty <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (req) begin
            r_index <= index;
            r_hit   <= hit;
            r_miss  <= miss;
            r_bsel  <= block_select;
            r_mesi  <= MESI;
          end
        end
        StLookup: begin
          r_bits <= w_rd_bits;
          if (w_err) begin
            r_err <= 1'b1;
          end else begin
            r_victim_way  <= w_way;
            r_evict_dirty <= w_dirty;
            r_done        <= 1'b1;
          end
        end
        StUpdate: ;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < Sets; s++) r_plru[s] <= '0;
    end else if (r_state == StUpdate) begin
      r_plru[r_index] <= w_new_bits;
    end
  end

  assign ready       = (r_state == StIdle);
  assign done        = r_done;
  assign err         = r_err;
  assign victim_way  = r_victim_way;
  assign evict_dirty = r_evict_dirty;

`ifdef PLRU_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt, r_evict_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_evict_cnt <= '0;
    end else if (r_state == StUpdate) begin
      if (r_hit && r_hit_cnt != '1)             r_hit_cnt   <= r_hit_cnt + 32'd1;
      if (r_miss && r_miss_cnt != '1)           r_miss_cnt  <= r_miss_cnt + 32'd1;
      if (r_evict_dirty && r_evict_cnt != '1)   r_evict_cnt <= r_evict_cnt + 32'd1;
    end
  end

  assign hit_count   = r_hit_cnt;
  assign miss_count  = r_miss_cnt;
  assign evict_count = r_evict_cnt;
`else
  assign hit_count   = '0;
  assign miss_count  = '0;
  assign evict_count = '0;
`endif

endmodule
